// File: rtl/melody_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | melody_pkg                                                                 |
// | Shared state encoding and code defaults for the melody sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package melody_pkg;

    localparam int MIN_STEP      = 3;
    localparam int DEF_END_CODE  = 0;
    localparam int DEF_REST_CODE = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_PLAY  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/melody_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | melody_sequencer_if                                                        |
// | Control, note-ROM and tone-generator signals of the melody sequencer.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface melody_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int NOTE_W = 8,
    parameter int TICK_W = 24
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] start_addr;
    logic [TICK_W-1:0] step_ticks;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] note;
    logic              gate;
    logic              note_on;
    logic              busy;
    logic              done;

    modport slave (
        input  start, stop, loop_en, start_addr, step_ticks, rom_data,
        output rom_addr, note, gate, note_on, busy, done
    );

    modport master (
        output start, stop, loop_en, start_addr, step_ticks, rom_data,
        input  rom_addr, note, gate, note_on, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/melody_sequencer_step_timer.sv
// +----------------------------------------------------------------------------+
// | step_timer                                                                 |
// | Loadable down-counter flagging the early-fetch point and the step end.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module step_timer
    import melody_pkg::*;
#(
    parameter int TICK_W = 24
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load,
    input  wire logic [TICK_W-1:0] load_val,
    output logic                   fetch_early,
    output logic                   step_end
);

    localparam logic [TICK_W-1:0] c_fetch_pt = TICK_W'(MIN_STEP - 1);

    logic [TICK_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Fetch leaves two clocks (FETCH + WAIT) before the next capture edge.
    assign fetch_early = (r_cnt == c_fetch_pt);
    assign step_end    = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/melody_sequencer.sv
// +----------------------------------------------------------------------------+
// | melody_sequencer                                                           |
// | Steps through an external note ROM at a programmable tempo.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int NOTE_W    = 8,
    parameter int TICK_W    = 24,
    parameter int END_CODE  = DEF_END_CODE,
    parameter int REST_CODE = DEF_REST_CODE
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    melody_sequencer_if.slave    bus
);

    localparam logic [NOTE_W-1:0] c_end        = NOTE_W'(END_CODE);
    localparam logic [NOTE_W-1:0] c_rest       = NOTE_W'(REST_CODE);
    localparam logic [TICK_W-1:0] c_min_step   = TICK_W'(MIN_STEP);
    localparam logic [TICK_W-1:0] c_start_load = TICK_W'(MIN_STEP - 2);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_loop_addr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [TICK_W-1:0] r_step_len;
    logic              r_restart;
    logic              r_wrap;
    logic [NOTE_W-1:0] r_note;
    logic              r_gate;
    logic              r_note_on;
    logic              r_busy;
    logic              r_done;

    logic [TICK_W-1:0] w_ticks_clamped;
    logic              w_is_end;
    logic              w_capture;
    logic              w_load;
    logic [TICK_W-1:0] w_load_val;
    logic              w_fetch_early;
    logic              w_step_end;

    assign w_ticks_clamped = (bus.step_ticks < c_min_step) ? c_min_step : bus.step_ticks;
    assign w_is_end        = (bus.rom_data == c_end) || r_wrap;
    assign w_capture       = (r_state == ST_WAIT) && w_step_end;
    assign w_load          = !bus.stop && (bus.start || w_capture);

    // A loop restart re-samples the tempo for the silent step it begins.
    always_comb begin
        w_load_val = c_start_load;
        if (!bus.start) begin
            w_load_val = w_is_end ? (w_ticks_clamped - 1'b1) : (r_step_len - 1'b1);
        end
    end

    step_timer #(
        .TICK_W (TICK_W)
    ) u_step_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_load),
        .load_val    (w_load_val),
        .fetch_early (w_fetch_early),
        .step_end    (w_step_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_loop_addr <= '0;
            r_rom_addr  <= '0;
            r_step_len  <= '0;
            r_restart   <= 1'b0;
            r_wrap      <= 1'b0;
            r_note      <= '0;
            r_gate      <= 1'b0;
            r_note_on   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_note_on <= 1'b0;
            r_done    <= 1'b0;
            if (bus.stop) begin
                r_state   <= ST_IDLE;
                r_note    <= '0;
                r_gate    <= 1'b0;
                r_busy    <= 1'b0;
                r_restart <= 1'b0;
                r_wrap    <= 1'b0;
            end else if (bus.start) begin
                r_state     <= ST_FETCH;
                r_ptr       <= bus.start_addr;
                r_loop_addr <= bus.start_addr;
                r_rom_addr  <= bus.start_addr;
                r_step_len  <= w_ticks_clamped;
                r_busy      <= 1'b1;
                r_restart   <= 1'b0;
                r_wrap      <= 1'b0;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        r_rom_addr <= r_ptr;
                        r_state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_step_end) begin
                            if (w_is_end) begin
                                r_note <= '0;
                                r_gate <= 1'b0;
                                r_wrap <= 1'b0;
                                if (bus.loop_en) begin
                                    r_ptr      <= r_loop_addr;
                                    r_restart  <= 1'b1;
                                    r_step_len <= w_ticks_clamped;
                                    r_state    <= ST_PLAY;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end
                            end else if (bus.rom_data == c_rest) begin
                                r_note  <= '0;
                                r_gate  <= 1'b0;
                                r_state <= ST_PLAY;
                            end else begin
                                // Same note after a gated step is held without a new strike.
                                r_note    <= bus.rom_data;
                                r_gate    <= 1'b1;
                                r_note_on <= !(r_gate && (r_note == bus.rom_data));
                                r_state   <= ST_PLAY;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (w_fetch_early) begin
                            if (r_restart) begin
                                r_rom_addr <= r_ptr;
                                r_restart  <= 1'b0;
                            end else begin
                                r_ptr      <= r_ptr + 1'b1;
                                r_rom_addr <= r_ptr + 1'b1;
                                r_wrap     <= &r_ptr;
                            end
                            r_state <= ST_FETCH;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.note     = r_note;
    assign bus.gate     = r_gate;
    assign bus.note_on  = r_note_on;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_melody_sequencer                                                        |
// | Directed vector bench for melody_sequencer with a behavioural note ROM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_melody_sequencer;

    typedef struct {
        int         cyc;
        int         act;      // 0 none, 1 stop pulse, 2 start at 200
        bit         chk_addr;
        logic [8:0] addr;
        logic [7:0] note;
        logic       gate;
        logic       note_on;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_on;
    int   n_done;
    logic [7:0] rom [0:511];
    vec_t vq[$];

    melody_sequencer_if bus ();

    melody_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.note_on) n_on = n_on + 1;
            if (bus.done)    n_done = n_done + 1;
        end
    end

    function automatic vec_t v(int cyc, int act, bit ca, int addr, int note,
                               bit g, bit on, bit b, bit d);
        vec_t r;
        r.cyc = cyc; r.act = act; r.chk_addr = ca; r.addr = 9'(addr);
        r.note = 8'(note); r.gate = g; r.note_on = on; r.busy = b; r.done = d;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string scen, input vec_t e);
        logic [11:0] got;
        logic [11:0] exp;
        got = {bus.note, bus.gate, bus.note_on, bus.busy, bus.done};
        exp = {e.note, e.gate, e.note_on, e.busy, e.done};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc %0d {note,gate,on,busy,done}: got %h expected %h",
                     scen, e.cyc, got, exp);
        end
        if (e.chk_addr) chk($sformatf("%s cyc %0d rom_addr", scen, e.cyc),
                            int'(bus.rom_addr), int'(e.addr));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 8'd0;
    endtask

    // Start pulse is sampled at edge s; cycle c is checked just after edge s+c.
    task automatic run(input string scen, input int sa, input int ticks,
                       input bit le, input int last);
        int idx;
        idx = 0;
        @(negedge clk);
        bus.start_addr = 9'(sa);
        bus.step_ticks = 24'(ticks);
        bus.loop_en    = le;
        bus.start      = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            while (idx < vq.size() && vq[idx].cyc == c) begin
                check_vec(scen, vq[idx]);
                if (vq[idx].act == 1) bus.stop = 1'b1;
                if (vq[idx].act == 2) begin
                    bus.start_addr = 9'd200;
                    bus.start      = 1'b1;
                end
                idx++;
            end
        end
        chk({scen, " vectors applied"}, idx, vq.size());
    endtask

    initial begin
        int b_on;
        int b_done;
        checks = 0; failures = 0; n_on = 0; n_done = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        bus.start_addr = '0; bus.step_ticks = '0;
        clear_rom();
        repeat (2) @(negedge clk);
        check_vec("reset", v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Legato melody, non-looping
        rom[0] = 8'd61; rom[1] = 8'd63; rom[2] = 8'd63; rom[3] = 8'd61; rom[4] = 8'd0;
        b_on = n_on; b_done = n_done;
        vq = {};
        vq.push_back(v(0,  0, 1, 0, 0,  0, 0, 1, 0));
        vq.push_back(v(2,  0, 0, 0, 61, 1, 1, 1, 0));
        vq.push_back(v(3,  0, 0, 0, 61, 1, 0, 1, 0));
        vq.push_back(v(11, 0, 0, 0, 61, 1, 0, 1, 0));
        vq.push_back(v(12, 0, 0, 0, 63, 1, 1, 1, 0));
        vq.push_back(v(22, 0, 0, 0, 63, 1, 0, 1, 0));
        vq.push_back(v(32, 0, 0, 0, 61, 1, 1, 1, 0));
        vq.push_back(v(40, 0, 1, 4, 61, 1, 0, 1, 0));
        vq.push_back(v(42, 0, 0, 0, 0,  0, 0, 0, 1));
        vq.push_back(v(43, 0, 0, 0, 0,  0, 0, 0, 0));
        run("legato", 0, 10, 1'b0, 44);
        chk("legato note_on count", n_on - b_on, 3);
        chk("legato done count", n_done - b_done, 1);

        // Looping with a silent end step, then stop mid-note
        b_on = n_on; b_done = n_done;
        vq = {};
        vq.push_back(v(32, 0, 0, 0, 61, 1, 1, 1, 0));
        vq.push_back(v(42, 0, 0, 0, 0,  0, 0, 1, 0));
        vq.push_back(v(50, 0, 1, 0, 0,  0, 0, 1, 0));
        vq.push_back(v(52, 0, 0, 0, 61, 1, 1, 1, 0));
        vq.push_back(v(62, 0, 0, 0, 63, 1, 1, 1, 0));
        vq.push_back(v(66, 1, 0, 0, 63, 1, 0, 1, 0));
        vq.push_back(v(67, 0, 0, 0, 0,  0, 0, 0, 0));
        vq.push_back(v(69, 0, 0, 0, 0,  0, 0, 0, 0));
        run("loop", 0, 10, 1'b1, 70);
        chk("loop note_on count", n_on - b_on, 5);
        chk("loop done count", n_done - b_done, 0);

        // Restart while busy at a new address
        rom[200] = 8'd80; rom[201] = 8'd0;
        b_on = n_on; b_done = n_done;
        vq = {};
        vq.push_back(v(14, 2, 0, 0,   63, 1, 0, 1, 0));
        vq.push_back(v(15, 0, 1, 200, 63, 1, 0, 1, 0));
        vq.push_back(v(17, 0, 0, 0,   80, 1, 1, 1, 0));
        vq.push_back(v(26, 0, 0, 0,   80, 1, 0, 1, 0));
        vq.push_back(v(27, 0, 0, 0,   0,  0, 0, 0, 1));
        run("restart", 0, 10, 1'b0, 29);
        chk("restart note_on count", n_on - b_on, 3);
        chk("restart done count", n_done - b_done, 1);

        // Note, rest, note
        clear_rom();
        rom[100] = 8'd65; rom[101] = 8'd1; rom[102] = 8'd65; rom[103] = 8'd0;
        b_on = n_on; b_done = n_done;
        vq = {};
        vq.push_back(v(0,  0, 1, 100, 0,  0, 0, 1, 0));
        vq.push_back(v(2,  0, 0, 0,   65, 1, 1, 1, 0));
        vq.push_back(v(6,  0, 0, 0,   65, 1, 0, 1, 0));
        vq.push_back(v(7,  0, 0, 0,   0,  0, 0, 1, 0));
        vq.push_back(v(11, 0, 0, 0,   0,  0, 0, 1, 0));
        vq.push_back(v(12, 0, 0, 0,   65, 1, 1, 1, 0));
        vq.push_back(v(17, 0, 0, 0,   0,  0, 0, 0, 1));
        vq.push_back(v(18, 0, 0, 0,   0,  0, 0, 0, 0));
        run("rest", 100, 5, 1'b0, 19);
        chk("rest note_on count", n_on - b_on, 2);
        chk("rest done count", n_done - b_done, 1);

        // Minimum step length and address wrap as end marker
        clear_rom();
        rom[510] = 8'd70; rom[511] = 8'd72;
        b_on = n_on; b_done = n_done;
        vq = {};
        vq.push_back(v(0, 0, 1, 510, 0,  0, 0, 1, 0));
        vq.push_back(v(2, 0, 0, 0,   70, 1, 1, 1, 0));
        vq.push_back(v(3, 0, 1, 511, 70, 1, 0, 1, 0));
        vq.push_back(v(5, 0, 0, 0,   72, 1, 1, 1, 0));
        vq.push_back(v(6, 0, 1, 0,   72, 1, 0, 1, 0));
        vq.push_back(v(8, 0, 0, 0,   0,  0, 0, 0, 1));
        vq.push_back(v(9, 0, 0, 0,   0,  0, 0, 0, 0));
        run("wrap", 510, 1, 1'b0, 10);
        chk("wrap note_on count", n_on - b_on, 2);
        chk("wrap done count", n_done - b_done, 1);

        // Simultaneous start and stop while idle
        b_on = n_on;
        @(negedge clk);
        bus.start_addr = 9'd510; bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("start+stop busy", int'(bus.busy), 0);
        repeat (4) @(negedge clk);
        chk("start+stop still idle", int'(bus.busy), 0);
        chk("start+stop no note_on", n_on - b_on, 0);

        // Asynchronous reset mid-PLAY
        rom[0] = 8'd61; rom[1] = 8'd0;
        @(negedge clk);
        bus.start_addr = 9'd0; bus.step_ticks = 24'd10; bus.loop_en = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset gate", int'(bus.gate), 1);
        #2 rst_n = 1'b0;
        #1;
        check_vec("async reset", v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
